// File: rtl/ofdm_cp_remover.sv
// ofdm_cp_remover: strips the cyclic prefix from each OFDM symbol after a start-of-frame marker.
// Body samples pass through combinationally with tlast per symbol and o_sof on the frame's first sample.
module setting_reg #(
  parameter logic [7:0]  ADDR = 8'd0,
  parameter logic [15:0] INIT = 16'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [15:0] set_data,
  output logic [15:0] out_o
);
  always_ff @(posedge clk or posedge reset)
    if (reset) out_o <= INIT;
    else if (set_stb && set_addr == ADDR) out_o <= set_data;
endmodule

module ofdm_cp_remover #(
  parameter logic [7:0] SR_FFT_SIZE    = 8'd134,
  parameter logic [7:0] SR_CP_LEN      = 8'd135,
  parameter logic [7:0] SR_NUM_SYMBOLS = 8'd136,
  parameter int         WIDTH          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  input  logic             i_sof,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_sof,
  output logic             sof_err
);
  typedef enum logic [1:0] {IDLE, CP, BODY} state_t;
  state_t state_q, state_d;
  logic [15:0] samp_q, samp_d, sym_q, sym_d;
  logic [15:0] fft_q, fft_d, cp_q, cp_d, nsym_q, nsym_d;
  logic [15:0] fft_set, cp_set, nsym_set;
  logic [15:0] fft_e, cp_e, nsym_e, samp_e, sym_e;
  logic sof_err_q, sof_err_d, sof_start, pass, last, acc;
  logic unused_ok;
  assign unused_ok = ^{i_tlast, set_data[31:16]};
  setting_reg #(.ADDR(SR_FFT_SIZE), .INIT(16'd64)) u_fft (
    .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data[15:0]), .out_o(fft_set));
  setting_reg #(.ADDR(SR_CP_LEN), .INIT(16'd16)) u_cp (
    .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data[15:0]), .out_o(cp_set));
  setting_reg #(.ADDR(SR_NUM_SYMBOLS), .INIT(16'd0)) u_nsym (
    .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data[15:0]), .out_o(nsym_set));
  // A frame-start beat uses the fresh settings and zeroed counters in the same cycle,
  // so a zero-length CP can pass that very beat through as body sample 0.
  always_comb begin
    sof_start = state_q != BODY && i_tvalid && i_sof;
    fft_e     = sof_start ? fft_set : fft_q;
    cp_e      = sof_start ? cp_set : cp_q;
    nsym_e    = sof_start ? nsym_set : nsym_q;
    samp_e    = sof_start ? 16'd0 : samp_q;
    sym_e     = sof_start ? 16'd0 : sym_q;
    pass      = state_q == BODY || (sof_start && cp_set == 16'd0 && fft_set != 16'd0);
    last      = pass && samp_e == fft_e - 16'd1;
    i_tready  = !reset && (pass ? o_tready : 1'b1);
    o_tvalid  = !reset && pass && i_tvalid;
    o_tdata   = (!reset && pass) ? i_tdata : '0;
    o_tlast   = !reset && last;
    o_sof     = !reset && pass && sym_e == 16'd0 && samp_e == 16'd0;
    sof_err   = sof_err_q;
    acc       = i_tvalid && i_tready;
  end
  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    sym_d     = sym_q;
    fft_d     = fft_q;
    cp_d      = cp_q;
    nsym_d    = nsym_q;
    sof_err_d = state_q == BODY && acc && i_sof;
    if (acc) begin
      if (sof_start) begin
        fft_d  = fft_set;
        cp_d   = cp_set;
        nsym_d = nsym_set;
        sym_d  = 16'd0;
      end
      if (pass) begin
        samp_d  = last ? 16'd0 : samp_e + 16'd1;
        sym_d   = last ? sym_e + 16'd1 : sym_e;
        state_d = !last ? BODY :
                  (nsym_e != 16'd0 && sym_e == nsym_e - 16'd1) ? IDLE :
                  cp_e == 16'd0 ? BODY : CP;
      end else if (sof_start) begin
        samp_d  = cp_set == 16'd1 ? 16'd0 : 16'd1;
        state_d = fft_set == 16'd0 ? IDLE : cp_set == 16'd1 ? BODY : CP;
      end else if (state_q == CP) begin
        samp_d  = samp_q == cp_q - 16'd1 ? 16'd0 : samp_q + 16'd1;
        state_d = samp_q == cp_q - 16'd1 ? BODY : CP;
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      samp_q    <= '0;
      sym_q     <= '0;
      fft_q     <= 16'd64;
      cp_q      <= 16'd16;
      nsym_q    <= 16'd0;
      sof_err_q <= 1'b0;
    end else if (clear) begin
      state_q   <= IDLE;
      samp_q    <= '0;
      sym_q     <= '0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      sym_q     <= sym_d;
      fft_q     <= fft_d;
      cp_q      <= cp_d;
      nsym_q    <= nsym_d;
      sof_err_q <= sof_err_d;
    end
endmodule

// File: doc/ofdm_cp_remover.md
Name: ofdm_cp_remover

Overview:
- Stage directly downstream of schmidl_cox in the OFDM receive chain.
- Waits for the start-of-frame marker, then splits the stream into OFDM symbols.
- Drops the cyclic prefix of each symbol and passes exactly FFT-size samples per symbol, with tlast on each symbol's final sample, so the FFT can consume the output directly.
- Configured over the settings bus; frame geometry is latched at each start of frame.

Parameters:
SR_FFT_SIZE, 134, settings address of FFT size in samples (16 bits)
SR_CP_LEN, 135, settings address of cyclic prefix length in samples (16 bits)
SR_NUM_SYMBOLS, 136, settings address of symbols per frame (16 bits; 0 = unlimited)
WIDTH, 32, sample width (16-bit I in high half, 16-bit Q in low half)

Ports:
clk  in  1  block clock
reset  in  1  asynchronous active-high reset
clear  in  1  synchronous return to IDLE, registers kept
set_stb  in  1  settings strobe
set_addr  in  8  settings address
set_data  in  32  settings data
i_tdata  in  WIDTH  input sample
i_tlast  in  1  input packet boundary (ignored)
i_tvalid  in  1  input valid
i_tready  out  1  input ready
i_sof  in  1  frame start; qualified by i_tvalid, marks the first CP sample of symbol 0
o_tdata  out  WIDTH  output sample
o_tlast  out  1  last sample of a symbol
o_tvalid  out  1  output valid
o_tready  in  1  output ready
o_sof  out  1  high with the first output sample of symbol 0 of each frame
sof_err  out  1  one-cycle pulse: i_sof seen while in BODY

Behaviour:
- Settings:
  - Three setting_reg instances; reset values are fft_size = 64, cp_len = 16, num_symbols = 0.
  - Values are copied to active registers when an i_sof beat is accepted. Mid-frame writes do not affect the current frame.
- Counters (16 bits): samp_cnt counts within CP or BODY; sym_cnt counts symbols in the frame.
- States: IDLE, CP, BODY.
- IDLE:
  - i_tready = 1; all samples are dropped.
  - On an accepted beat with i_sof: latch the settings and set sym_cnt = 0.
  - That beat is the first CP sample. If cp_len == 0 it is instead the first BODY sample, passed through under BODY rules.
  - Next state is CP, or BODY when cp_len == 0. If cp_len == 1, that beat completes the CP and the next state is BODY.
  - If the latched fft_size == 0, the block stays in IDLE.
- CP:
  - i_tready = 1; samples are dropped.
  - samp_cnt increments per accepted beat. On the beat where samp_cnt == cp_len-1, go to BODY with samp_cnt = 0.
  - An accepted i_sof in CP restarts the frame: re-latch settings, sym_cnt = 0, and that beat is CP sample 0.
- BODY:
  - Combinational pass-through, zero latency:
    - o_tdata = i_tdata
    - o_tvalid = i_tvalid
    - i_tready = o_tready
  - o_tlast = (samp_cnt == fft_size-1).
  - o_sof = (sym_cnt == 0 && samp_cnt == 0).
  - Counters advance only on an output handshake.
  - On the tlast beat, sym_cnt increments. If num_symbols != 0 and sym_cnt == num_symbols-1, go to IDLE. Otherwise go to CP (or stay in BODY with samp_cnt = 0 when cp_len == 0).
  - i_sof during BODY: the sample passes normally and sof_err pulses for one cycle (registered, asserted the cycle after the beat). No resync occurs, so symbols are never truncated.
- Outputs outside BODY: o_tvalid = 0, o_tlast = 0, o_sof = 0.
- Reset (asynchronous):
  - Goes to IDLE immediately; counters = 0, sof_err = 0.
  - All outputs are 0 while reset is held, including i_tready.
  - Reset mid-symbol discards the partial symbol with no tlast.
- clear: same effect as reset on the next clock edge, but settings are retained.
- Backpressure: o_tready low in BODY stalls input (i_tready low). CP/IDLE dropping never depends on o_tready.
- Counter wrap is impossible; all comparisons are against latched 16-bit values minus 1 (computed only when the value is non-zero).

Test Plan:
- fft=64, cp=16, nsym=2; 200 samples with i_sof on sample 10 (values = index). Output is 128 samples: 26..89 with tlast on 89, then 106..169 with tlast on 169. o_sof on sample 26 only. Samples 170+ dropped.
- Same config, o_tready toggled randomly at 50%. Output sequence identical; no drops or duplicates. i_tready tracks o_tready in BODY and is 1 elsewhere.
- cp=0, fft=4, nsym=0; i_sof on sample 0. Continuous symbols 0..3, 4..7, …, each with tlast. A second i_sof at sample 6 passes data and sof_err pulses once.
- i_sof at sample 0, then i_sof at sample 5 (cp=16). Restart: first output sample is 21.
- Write fft=32 during a frame with fft=64. Current frame emits 64-sample symbols; the next frame emits 32-sample symbols.
- Assert reset in mid-BODY for 1 cycle. Outputs go to 0 asynchronously; the block stays in IDLE until the next i_sof.
